ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
- Pointer/flag controller that turns the team's simple dual-port RAM (one write port, one read port, registered 1-cycle read) into a synchronous FIFO.
- Sits directly upstream of the RAM and drives its wr_enb, rd_enb, wr_addr and rd_addr.
- Write data goes straight to the RAM data input. This block handles control only: push/pop acceptance, occupancy, flags, and a read-valid strobe aligned to RAM data_out.

Parameters:
- WIDTH, 8, data width of the attached RAM (for documentation/consistency only; no data path inside).
- DEPTH, 16, number of RAM entries; must equal 2**ADDRESS.
- ADDRESS, 4, RAM address width.
- AF_LEVEL, 12, almost-full threshold (count >= AF_LEVEL); used only with the optional feature.
- AE_LEVEL, 2, almost-empty threshold (count <= AE_LEVEL); used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- push  in  1  write request; data is presented on the RAM data input in the same cycle
- pop  in  1  read request
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  ADDRESS+1  current occupancy, 0..DEPTH
- ram_wr_enb  out  1  to RAM wr_enb; high for an accepted push
- ram_wr_addr  out  ADDRESS  to RAM wr_addr
- ram_rd_enb  out  1  to RAM rd_enb; high for an accepted pop
- ram_rd_addr  out  ADDRESS  to RAM rd_addr
- rd_valid  out  1  RAM data_out holds the popped word this cycle
- overflow  out  1  sticky: push rejected while full
- underflow  out  1  sticky: pop rejected while empty
- almost_full  out  1  optional-feature flag
- almost_empty  out  1  optional-feature flag

Behaviour:
- Reset (reset=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, count=0.
  - empty=1, full=0, rd_valid=0, overflow=0, underflow=0.
  - almost_empty=1, almost_full=0.
  - RAM contents are not relied on after reset.
  - Reset mid-operation discards all entries and any pending rd_valid.
- Acceptance (combinational from the current registered state):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - Push on full is accepted only when a pop is accepted in the same cycle.
  - Pop on empty is always rejected, even with a simultaneous push; there is no read-through.
- RAM drive (combinational):
  - ram_wr_enb=push_ok, ram_wr_addr=wr_ptr.
  - ram_rd_enb=pop_ok, ram_rd_addr=rd_ptr.
  - Full with push_ok and pop_ok gives wr_addr==rd_addr. This is legal: the RAM returns the old entry and then writes the new one.
- Pointer update on clock edge:
  - wr_ptr += push_ok; rd_ptr += pop_ok.
  - ADDRESS-bit modulo wrap: DEPTH-1 -> 0.
- Count update:
  - count += push_ok - pop_ok (net 0 when both are accepted).
  - Never exceeds DEPTH, never goes below 0.
- Flags: full, empty and almost_* are registered, derived from the next count, and valid in the same cycle as count.
- Read latency: rd_valid is a register set to pop_ok. It is high exactly one cycle after an accepted pop, when RAM data_out carries the word. Back-to-back pops give back-to-back rd_valid.
- Errors:
  - overflow sets on push & ~push_ok; underflow sets on pop & ~pop_ok.
  - Both hold until reset; rejected requests do not change state.
- Ordering: strict FIFO; the n-th accepted pop returns the n-th accepted push.

Optional Feature:
- Macro: RAM_FIFO_ALMOST_EN.
- Defined: almost_full = (count >= AF_LEVEL) and almost_empty = (count <= AE_LEVEL), both registered and updated with count.
- Undefined: no threshold logic is built; almost_full is tied to 0 and almost_empty to 1. Ports remain present so the interface is unchanged.

Test Plan:
- Reset with reset=0 mid-stream after 5 pushes -> immediately count=0, empty=1, full=0, rd_valid=0, flags cleared; next push writes addr 0.
- Push 16 words 0x10..0x1F, then pop 16 -> full=1 after the 16th push; each rd_valid cycle shows data_out 0x10..0x1F in order; empty=1 at the end, no error flags.
- Fill to full, then push+pop together for 4 cycles -> count stays 16, full stays 1, ram_wr_addr==ram_rd_addr each cycle, popped data is the oldest entries.
- When empty, push+pop together -> pop rejected, underflow=1, count=1, ram_rd_enb=0; when full, push alone -> overflow=1, count stays 16.
- Wrap: 10 pushes, 10 pops, 10 pushes -> ram_wr_addr goes 10..15,0..3; data order preserved across the wrap.
- With RAM_FIFO_ALMOST_EN: almost_full rises in the cycle count becomes 12 and almost_empty falls when count becomes 3; without the macro: almost_full=0 and almost_empty=1 throughout.

Source files
------------

// File: rtl/ram_fifo_ctrl.sv
// Pointer/flag controller that turns a simple dual-port RAM (registered read) into a synchronous FIFO.
// Optional threshold flags are built when RAM_FIFO_ALMOST_EN is defined; otherwise they are tied off.
module ram_fifo_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int ADDRESS  = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [ADDRESS:0]   count,
  output logic               ram_wr_enb,
  output logic [ADDRESS-1:0] ram_wr_addr,
  output logic               ram_rd_enb,
  output logic [ADDRESS-1:0] ram_rd_addr,
  output logic               rd_valid,
  output logic               overflow,
  output logic               underflow,
  output logic               almost_full,
  output logic               almost_empty
);

  localparam int CNT_W = ADDRESS + 1;

  // Pointer wrap relies on DEPTH being exactly the RAM address space.
  if (DEPTH != (1 << ADDRESS) || WIDTH < 1 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_bad_cfg
    $error("ram_fifo_ctrl: inconsistent DEPTH/ADDRESS/WIDTH/threshold parameters");
  end

  logic [ADDRESS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               pop_ok;
  logic               push_ok;

  always_comb begin
    pop_ok  = pop & ~empty_q;
    push_ok = push & (~full_q | pop_ok);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDRESS'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDRESS'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);
    rd_valid_d = pop_ok;
    if (push & ~push_ok) overflow_d  = 1'b1;
    if (pop & ~pop_ok)   underflow_d = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef RAM_FIFO_ALMOST_EN
  logic almost_full_q, almost_full_d;
  logic almost_empty_q, almost_empty_d;

  always_comb begin
    almost_full_d  = (count_d >= CNT_W'(AF_LEVEL));
    almost_empty_d = (count_d <= CNT_W'(AE_LEVEL));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b1;
`endif

  // At full with push and pop both accepted, wr_addr == rd_addr; the RAM reads the old word first.
  assign ram_wr_enb  = push_ok;
  assign ram_wr_addr = wr_ptr_q;
  assign ram_rd_enb  = pop_ok;
  assign ram_rd_addr = rd_ptr_q;

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural registered-read RAM attached.
// Define RAM_FIFO_ALMOST_EN on both files to exercise the threshold flags.
module tb_ram_fifo_ctrl;

  logic       clock;
  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] din;
  logic       full, empty, rd_valid, overflow, underflow, almost_full, almost_empty;
  logic [4:0] count;
  logic       ram_wr_enb, ram_rd_enb;
  logic [3:0] ram_wr_addr, ram_rd_addr;

  logic [7:0] mem [16];
  logic [7:0] ram_dout;

  int checks = 0;
  int errors = 0;

  ram_fifo_ctrl #(.WIDTH(8), .DEPTH(16), .ADDRESS(4), .AF_LEVEL(12), .AE_LEVEL(2)) dut (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .full(full), .empty(empty), .count(count),
    .ram_wr_enb(ram_wr_enb), .ram_wr_addr(ram_wr_addr),
    .ram_rd_enb(ram_rd_enb), .ram_rd_addr(ram_rd_addr),
    .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow),
    .almost_full(almost_full), .almost_empty(almost_empty)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Read-before-write RAM with a one-cycle registered read port.
  always @(posedge clock) begin
    if (ram_rd_enb) ram_dout <= mem[ram_rd_addr];
    if (ram_wr_enb) mem[ram_wr_addr] <= din;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    push = 1'b0; pop = 1'b0; din = 8'h00;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic push_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; din = base + 8'(i);
      tick();
    end
    push = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags empty=%b full=%b exp 1 0", empty, full); end
    checks++; if (rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_status rv=%b ov=%b un=%b exp 0 0 0", rd_valid, overflow, underflow); end
    checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost af=%b ae=%b exp 0 1", almost_full, almost_empty); end
    push_words(5, 8'h01);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    checks++; if (count !== 5'd4 || rd_valid !== 1'b1) begin errors++; $display("FAIL midstream count=%0d rv=%b exp 4 1", count, rd_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL async_reset count=%0d empty=%b full=%b exp 0 1 0", count, empty, full); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL async_reset_rv got %b exp 0", rd_valid); end
    tick();
    reset = 1'b1;
    tick();
    push = 1'b1; din = 8'hAA;
    #1;
    checks++; if (ram_wr_enb !== 1'b1 || ram_wr_addr !== 4'd0) begin errors++; $display("FAIL post_reset_wr en=%b addr=%0d exp 1 0", ram_wr_enb, ram_wr_addr); end
    tick();
    push = 1'b0;
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL post_reset_count got %0d exp 1", count); end
  endtask

  task automatic test_fill_drain();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; din = 8'h10 + 8'(i);
      #1;
      checks++; if (ram_wr_enb !== 1'b1 || ram_wr_addr !== 4'(i)) begin errors++; $display("FAIL fill_wr[%0d] en=%b addr=%0d exp 1 %0d", i, ram_wr_enb, ram_wr_addr, i); end
      tick();
      checks++; if (count !== 5'(i + 1) || full !== (i == 15)) begin errors++; $display("FAIL fill_cnt[%0d] count=%0d full=%b exp %0d %b", i, count, full, i + 1, (i == 15)); end
    end
    push = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pop = 1'b1;
      #1;
      checks++; if (ram_rd_enb !== 1'b1 || ram_rd_addr !== 4'(i)) begin errors++; $display("FAIL drain_rd[%0d] en=%b addr=%0d exp 1 %0d", i, ram_rd_enb, ram_rd_addr, i); end
      tick();
      checks++; if (rd_valid !== 1'b1 || ram_dout !== 8'h10 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d] rv=%b data=%h exp 1 %h", i, rd_valid, ram_dout, 8'h10 + 8'(i)); end
    end
    pop = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL drain_end rv=%b empty=%b count=%0d exp 0 1 0", rd_valid, empty, count); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL drain_err ov=%b un=%b exp 0 0", overflow, underflow); end
  endtask

  task automatic test_full_simul();
    apply_reset();
    push_words(16, 8'h20);
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; pop = 1'b1; din = 8'h30 + 8'(i);
      #1;
      checks++; if (ram_wr_enb !== 1'b1 || ram_rd_enb !== 1'b1 || ram_wr_addr !== 4'(i) || ram_rd_addr !== 4'(i)) begin
        errors++; $display("FAIL full_rw[%0d] we=%b re=%b wa=%0d ra=%0d exp 1 1 %0d %0d", i, ram_wr_enb, ram_rd_enb, ram_wr_addr, ram_rd_addr, i, i);
      end
      tick();
      checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL full_cnt[%0d] count=%0d full=%b exp 16 1", i, count, full); end
      checks++; if (rd_valid !== 1'b1 || ram_dout !== 8'h20 + 8'(i)) begin errors++; $display("FAIL full_data[%0d] rv=%b data=%h exp 1 %h", i, rd_valid, ram_dout, 8'h20 + 8'(i)); end
    end
    push = 1'b0; pop = 1'b0;
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL full_err ov=%b un=%b exp 0 0", overflow, underflow); end
  endtask

  task automatic test_errors();
    apply_reset();
    push = 1'b1; pop = 1'b1; din = 8'h77;
    #1;
    checks++; if (ram_rd_enb !== 1'b0 || ram_wr_enb !== 1'b1) begin errors++; $display("FAIL empty_pp re=%b we=%b exp 0 1", ram_rd_enb, ram_wr_enb); end
    tick();
    push = 1'b0; pop = 1'b0;
    checks++; if (underflow !== 1'b1 || overflow !== 1'b0 || count !== 5'd1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL underflow un=%b ov=%b count=%0d rv=%b exp 1 0 1 0", underflow, overflow, count, rd_valid);
    end
    push_words(15, 8'h60);
    checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL err_fill count=%0d full=%b exp 16 1", count, full); end
    push = 1'b1; din = 8'hEE;
    #1;
    checks++; if (ram_wr_enb !== 1'b0) begin errors++; $display("FAIL overflow_we got %b exp 0", ram_wr_enb); end
    tick();
    push = 1'b0;
    checks++; if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL overflow ov=%b count=%0d full=%b exp 1 16 1", overflow, count, full); end
    tick();
    checks++; if (overflow !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL sticky ov=%b un=%b exp 1 1", overflow, underflow); end
  endtask

  task automatic test_wrap();
    apply_reset();
    push_words(10, 8'h40);
    for (int i = 0; i < 10; i++) begin
      pop = 1'b1;
      tick();
      checks++; if (ram_dout !== 8'h40 + 8'(i)) begin errors++; $display("FAIL wrap_first[%0d] data=%h exp %h", i, ram_dout, 8'h40 + 8'(i)); end
    end
    pop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push = 1'b1; din = 8'h50 + 8'(i);
      #1;
      checks++; if (ram_wr_addr !== 4'((10 + i) % 16)) begin errors++; $display("FAIL wrap_waddr[%0d] got %0d exp %0d", i, ram_wr_addr, (10 + i) % 16); end
      tick();
    end
    push = 1'b0;
    checks++; if (count !== 5'd10) begin errors++; $display("FAIL wrap_count got %0d exp 10", count); end
    for (int i = 0; i < 10; i++) begin
      pop = 1'b1;
      #1;
      checks++; if (ram_rd_addr !== 4'((10 + i) % 16)) begin errors++; $display("FAIL wrap_raddr[%0d] got %0d exp %0d", i, ram_rd_addr, (10 + i) % 16); end
      tick();
      checks++; if (rd_valid !== 1'b1 || ram_dout !== 8'h50 + 8'(i)) begin errors++; $display("FAIL wrap_data[%0d] rv=%b data=%h exp 1 %h", i, rd_valid, ram_dout, 8'h50 + 8'(i)); end
    end
    pop = 1'b0;
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
  endtask

  task automatic test_almost();
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      push = 1'b1; din = 8'(i);
      tick();
`ifdef RAM_FIFO_ALMOST_EN
      checks++; if (almost_full !== (i + 1 >= 12) || almost_empty !== (i + 1 <= 2)) begin
        errors++; $display("FAIL almost[%0d] af=%b ae=%b exp %b %b", i + 1, almost_full, almost_empty, (i + 1 >= 12), (i + 1 <= 2));
      end
`else
      checks++; if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin errors++; $display("FAIL almost_off[%0d] af=%b ae=%b exp 0 1", i + 1, almost_full, almost_empty); end
`endif
    end
    push = 1'b0;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; din = 8'h00;
    #1;
    test_reset();
    test_fill_drain();
    test_full_simul();
    test_errors();
    test_wrap();
    test_almost();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
